// File: rtl/uart_tx_queue.sv
// Byte FIFO plus issue FSM feeding a UART transmitter through a strobe/busy handshake.
// Define UART_TXQ_OVF_STICKY_EN for a sticky overflow flag; otherwise ovf_o is a one-cycle pulse.

module uart_tx_queue #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned DATA_W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push_i,
    input  logic [DATA_W-1:0]   push_dat_i,
    input  logic                flush_i,
    output logic                full_o,
    output logic                empty_o,
    output logic [DEPTH_LOG2:0] count_o,
    output logic                ovf_o,
    input  logic                ovf_clr_i,
    output logic                uart_wr_o,
    output logic [DATA_W-1:0]   uart_dat_o,
    input  logic                uart_busy_i
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitBusy,
        StWaitDone
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_W-1:0]     r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [DEPTH_LOG2:0]   w_count_nxt;
    logic                  r_wr;
    logic                  w_wr_nxt;
    logic [DATA_W-1:0]     r_dat;
    logic                  r_ovf;
    logic                  w_pop;
    logic                  w_push_ok;
    logic                  w_ovf_evt;

    assign full_o     = (r_count == CNT_FULL);
    assign empty_o    = (r_count == '0);
    assign count_o    = r_count;
    assign uart_wr_o  = r_wr;
    assign uart_dat_o = r_dat;
    assign ovf_o      = r_ovf;

    // Fullness comes from the registered count, so a same-cycle pop never makes room.
    assign w_push_ok = push_i & ~full_o & ~flush_i;
    assign w_ovf_evt = push_i & full_o & ~flush_i;

    always_comb begin
        w_state_nxt = r_state;
        w_wr_nxt    = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            StIdle: begin
                if (r_count != '0) begin
                    w_pop       = 1'b1;
                    w_wr_nxt    = 1'b1;
                    w_state_nxt = StIssue;
                end
            end
            StIssue:    w_state_nxt = StWaitBusy;
            StWaitBusy: if (uart_busy_i) w_state_nxt = StWaitDone;
            StWaitDone: if (!uart_busy_i) w_state_nxt = StIdle;
            default:    w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        w_count_nxt = r_count;
        if (flush_i) begin
            w_count_nxt = '0;
        end else if (w_push_ok && !w_pop) begin
            w_count_nxt = r_count + CNT_ONE;
        end else if (!w_push_ok && w_pop) begin
            w_count_nxt = r_count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_wr     <= 1'b0;
            r_dat    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wr    <= w_wr_nxt;
            r_count <= w_count_nxt;
            if (w_pop) begin
                r_dat <= r_mem[r_rd_ptr];
            end
            // Flush drops queued bytes only; a byte already latched for the FSM still goes out.
            if (flush_i) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
                if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_dat_i;
        end
    end

`ifdef UART_TXQ_OVF_STICKY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_evt) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr_i) begin
            r_ovf <= 1'b0;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= w_ovf_evt;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: directed scenarios plus randomized traffic checked
// against a queue-based reference model and a simple transmitter busy model.

module tb_uart_tx_queue;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       push_i = 1'b0;
    logic [7:0] push_dat_i = 8'h00;
    logic       flush_i = 1'b0;
    logic       ovf_clr_i = 1'b0;
    logic       uart_busy_i = 1'b0;
    logic       full_o;
    logic       empty_o;
    logic [4:0] count_o;
    logic       ovf_o;
    logic       uart_wr_o;
    logic [7:0] uart_dat_o;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int busy_cnt = 0;
    bit tx_hold = 1'b0;
    bit tx_rand = 1'b0;

    // Reference model: queued bytes, transmitter-channel readiness, expected registered outputs.
    logic [7:0] m_q[$];
    bit         m_ready = 1'b1;
    bit         m_seen = 1'b0;
    bit         m_wr = 1'b0;
    bit         m_ovf = 1'b0;
    logic [7:0] m_dat = 8'h00;

    uart_tx_queue #(
        .DEPTH_LOG2(4),
        .DATA_W    (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push_i),
        .push_dat_i (push_dat_i),
        .flush_i    (flush_i),
        .full_o     (full_o),
        .empty_o    (empty_o),
        .count_o    (count_o),
        .ovf_o      (ovf_o),
        .ovf_clr_i  (ovf_clr_i),
        .uart_wr_o  (uart_wr_o),
        .uart_dat_o (uart_dat_o),
        .uart_busy_i(uart_busy_i)
    );

    initial forever #5 clk = ~clk;

    // Advance the model by one clock edge using the inputs of the cycle that is ending.
    task automatic model_step();
        bit full;
        bit ev;
        bit was_wr;
        if (rst) begin
            m_q.delete();
            m_ready = 1'b1;
            m_seen  = 1'b0;
            m_wr    = 1'b0;
            m_dat   = 8'h00;
            m_ovf   = 1'b0;
        end else begin
            full   = (m_q.size() == 16);
            ev     = push_i && full && !flush_i;
            was_wr = m_wr;
            m_wr   = 1'b0;
            if (m_ready && m_q.size() > 0) begin
                m_dat   = m_q.pop_front();
                m_ready = 1'b0;
                m_seen  = 1'b0;
                m_wr    = 1'b1;
            end else if (!m_ready && !was_wr) begin
                if (!m_seen) m_seen = (uart_busy_i === 1'b1);
                else if (uart_busy_i === 1'b0) m_ready = 1'b1;
            end
            if (flush_i) m_q.delete();
            else if (push_i && !full) m_q.push_back(push_dat_i);
`ifdef UART_TXQ_OVF_STICKY_EN
            if (ev) m_ovf = 1'b1;
            else if (ovf_clr_i) m_ovf = 1'b0;
`else
            m_ovf = ev;
`endif
        end
    endtask

    // One clock: update model, wait for the edge, then let the transmitter model react.
    task automatic tick();
        logic w;
        model_step();
        w = uart_wr_o;
        @(posedge clk);
        #1;
        cyc++;
        if (tx_hold) begin
            uart_busy_i = 1'b1;
        end else begin
            if (w === 1'b1) busy_cnt = tx_rand ? int'($urandom_range(8, 1)) : 10;
            if (busy_cnt > 0) begin
                uart_busy_i = 1'b1;
                busy_cnt--;
            end else begin
                uart_busy_i = 1'b0;
            end
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (!(m_q.size() == 0 && m_ready && busy_cnt == 0 && uart_busy_i === 1'b0)
               && k < 3000) begin
            tick();
            k++;
        end
        if (k >= 3000) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: count_o=%0d after %0d cycles, required idle", count_o, k);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({count_o, empty_o, full_o, uart_wr_o, ovf_o} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_flags: got cnt=%0d e=%b f=%b wr=%b ovf=%b, required 0 1 0 0 0",
                     count_o, empty_o, full_o, uart_wr_o, ovf_o);
        end
        n_checks++;
        if (uart_dat_o !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_dat: got %0h, required 0", uart_dat_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        push_i = 1'b1;
        push_dat_i = 8'hA5;
        tick();
        push_i = 1'b0;
        n_checks++;
        if (uart_wr_o !== 1'b0 || count_o !== 5'd1) begin
            n_fail++;
            $display("FAIL single_c1: got wr=%b cnt=%0d, required wr=0 cnt=1", uart_wr_o, count_o);
        end
        tick();
        n_checks++;
        if (uart_wr_o !== 1'b1 || uart_dat_o !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_c2_strobe: got wr=%b dat=%0h, required wr=1 dat=a5",
                     uart_wr_o, uart_dat_o);
        end
        n_checks++;
        if (count_o !== 5'd0 || empty_o !== 1'b1) begin
            n_fail++;
            $display("FAIL single_c2_count: got cnt=%0d e=%b, required 0 1", count_o, empty_o);
        end
        tick();
        n_checks++;
        if (uart_wr_o !== 1'b0 || uart_dat_o !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_c3: got wr=%b dat=%0h, required wr=0 dat=a5",
                     uart_wr_o, uart_dat_o);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int start;
        int last_fall;
        int n_str;
        bit prev_busy;
        logic [7:0] got[$];
        drain();
        start = cyc;
        last_fall = -100;
        n_str = 0;
        prev_busy = 1'b0;
        for (int c = 0; c < 60; c++) begin
            push_i = (c < 3);
            push_dat_i = 8'(c + 1);
            tick();
            if (prev_busy && uart_busy_i === 1'b0) last_fall = cyc;
            prev_busy = (uart_busy_i === 1'b1);
            if (uart_wr_o === 1'b1) begin
                n_checks++;
                if ((n_str == 0) ? (cyc - start != 2) : (cyc - last_fall != 2)) begin
                    n_fail++;
                    $display("FAIL b2b_timing: strobe %0d at cycle %0d, busy fell %0d, start %0d",
                             n_str, cyc, last_fall, start);
                end
                got.push_back(uart_dat_o);
                n_str++;
            end
        end
        push_i = 1'b0;
        n_checks++;
        if (n_str != 3) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d strobes, required 3", n_str);
        end
        for (int i = 0; i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== 8'(i + 1)) begin
                n_fail++;
                $display("FAIL b2b_data: strobe %0d got %0h, required %0h", i, got[i], i + 1);
            end
        end
        drain();
    endtask

    task automatic test_fill_ovf();
        drain();
        tx_hold = 1'b1;
        for (int c = 0; c < 17; c++) begin
            push_i = 1'b1;
            push_dat_i = 8'(c);
            tick();
        end
        push_i = 1'b0;
        n_checks++;
        if (count_o !== 5'd16 || full_o !== 1'b1 || empty_o !== 1'b0 || ovf_o !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full: got cnt=%0d f=%b e=%b ovf=%b, required 16 1 0 0",
                     count_o, full_o, empty_o, ovf_o);
        end
        push_i = 1'b1;
        push_dat_i = 8'h11;
        tick();
        push_i = 1'b0;
        n_checks++;
        if (ovf_o !== 1'b1 || count_o !== 5'd16) begin
            n_fail++;
            $display("FAIL fill_ovf_set: got ovf=%b cnt=%0d, required 1 16", ovf_o, count_o);
        end
        tick();
        n_checks++;
        if (ovf_o !== m_ovf) begin
            n_fail++;
            $display("FAIL fill_ovf_after: got %b, required %b", ovf_o, m_ovf);
        end
        push_i = 1'b1;
        push_dat_i = 8'h12;
        ovf_clr_i = 1'b1;
        tick();
        push_i = 1'b0;
        n_checks++;
        if (ovf_o !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_ovf_set_wins: got %b, required 1", ovf_o);
        end
        tick();
        ovf_clr_i = 1'b0;
        n_checks++;
        if (ovf_o !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_ovf_clr: got %b, required 0", ovf_o);
        end
    endtask

    task automatic test_full_pop();
        int k;
        tx_hold = 1'b0;
        k = 0;
        while (!m_ready && k < 20) begin
            tick();
            k++;
        end
        n_checks++;
        if (count_o !== 5'd16 || k >= 20) begin
            n_fail++;
            $display("FAIL fullpop_pre: got cnt=%0d wait=%0d, required cnt=16", count_o, k);
        end
        push_i = 1'b1;
        push_dat_i = 8'hEE;
        tick();
        push_i = 1'b0;
        n_checks++;
        if ({count_o, full_o, uart_wr_o, ovf_o} !== {5'd15, 1'b0, 1'b1, 1'b1}
            || uart_dat_o !== 8'h01) begin
            n_fail++;
            $display("FAIL fullpop: got cnt=%0d f=%b wr=%b ovf=%b dat=%0h, required 15 0 1 1 01",
                     count_o, full_o, uart_wr_o, ovf_o, uart_dat_o);
        end
    endtask

    task automatic test_flush();
        int n_str;
        bit fell;
        drain();
        for (int c = 0; c < 6; c++) begin
            push_i = 1'b1;
            push_dat_i = 8'(8'h30 + c);
            tick();
        end
        push_i = 1'b0;
        n_checks++;
        if (count_o !== 5'd5) begin
            n_fail++;
            $display("FAIL flush_pre: got cnt=%0d, required 5", count_o);
        end
        flush_i = 1'b1;
        push_i = 1'b1;
        push_dat_i = 8'h99;
        tick();
        flush_i = 1'b0;
        push_i = 1'b0;
        n_checks++;
        if (count_o !== 5'd0 || empty_o !== 1'b1 || ovf_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_count: got cnt=%0d e=%b ovf=%b, required 0 1 0",
                     count_o, empty_o, ovf_o);
        end
        n_str = 0;
        fell = 1'b0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (uart_wr_o === 1'b1) n_str++;
            if (uart_busy_i === 1'b0) fell = 1'b1;
        end
        n_checks++;
        if (n_str != 0 || !fell || uart_dat_o !== 8'h30) begin
            n_fail++;
            $display("FAIL flush_after: got strobes=%0d fell=%b dat=%0h, required 0 1 30",
                     n_str, fell, uart_dat_o);
        end
    endtask

    task automatic test_reset_issue();
        drain();
        push_i = 1'b1;
        push_dat_i = 8'h77;
        tick();
        push_dat_i = 8'h78;
        tick();
        push_i = 1'b0;
        n_checks++;
        if (uart_wr_o !== 1'b1 || count_o !== 5'd1) begin
            n_fail++;
            $display("FAIL rstiss_pre: got wr=%b cnt=%0d, required 1 1", uart_wr_o, count_o);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({uart_wr_o, count_o, empty_o} !== {1'b0, 5'd0, 1'b1} || uart_dat_o !== 8'h00) begin
            n_fail++;
            $display("FAIL rstiss_post: got wr=%b cnt=%0d e=%b dat=%0h, required 0 0 1 0",
                     uart_wr_o, count_o, empty_o, uart_dat_o);
        end
        tick();
        n_checks++;
        if (uart_wr_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rstiss_nostrobe: got wr=%b, required 0", uart_wr_o);
        end
        drain();
        push_i = 1'b1;
        push_dat_i = 8'h5A;
        tick();
        push_i = 1'b0;
        tick();
        n_checks++;
        if (uart_wr_o !== 1'b1 || uart_dat_o !== 8'h5A) begin
            n_fail++;
            $display("FAIL rstiss_new: got wr=%b dat=%0h, required 1 5a", uart_wr_o, uart_dat_o);
        end
        drain();
    endtask

    task automatic test_random();
        tx_rand = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            push_i     = ($urandom_range(99) < 50);
            push_dat_i = 8'($urandom);
            flush_i    = ($urandom_range(59) == 0);
            ovf_clr_i  = ($urandom_range(5) == 0);
            rst        = ($urandom_range(399) == 0);
            tick();
            n_checks++;
            if ({count_o, empty_o, full_o, uart_wr_o, uart_dat_o, ovf_o} !==
                {5'(m_q.size()), m_q.size() == 0, m_q.size() == 16, m_wr, m_dat, m_ovf}) begin
                n_fail++;
                $display("FAIL random_c%0d: got cnt=%0d e=%b f=%b wr=%b dat=%0h ovf=%b, required %0d %b %b %b %0h %b",
                         c, count_o, empty_o, full_o, uart_wr_o, uart_dat_o, ovf_o,
                         m_q.size(), m_q.size() == 0, m_q.size() == 16, m_wr, m_dat, m_ovf);
            end
        end
        push_i = 1'b0;
        flush_i = 1'b0;
        ovf_clr_i = 1'b0;
        rst = 1'b0;
        tx_rand = 1'b0;
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fill_ovf();
        test_full_pop();
        test_flush();
        test_reset_issue();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
